// File: rtl/pipe_stage_reg_if.sv
// Handshake/bus bundle between a pipeline stage and its inter-stage register.
// Optional exception/branch-delay fields appear when PIPE_EXC_EN is defined.
interface pipe_stage_reg_if #(
  parameter int DW    = 32,
  parameter int NLANE = 2,
  parameter int FW    = 4,
  parameter int HOLDW = 4
);
  logic                  en;
  logic                  flush;
  logic                  valid_in;
  logic [DW-1:0]         pc_in;
  logic [DW-1:0]         instr_in;
  logic [NLANE*DW-1:0]   lanes_in;
  logic [FW-1:0]         flags_in;
  logic [2:0]            fwd_sel;

  logic                  valid_out;
  logic [DW-1:0]         pc_out;
  logic [DW-1:0]         instr_out;
  logic [NLANE*DW-1:0]   lanes_out;
  logic [FW-1:0]         flags_out;
  logic [DW-1:0]         fwd_data;
  logic                  fwd_ok;
  logic [HOLDW-1:0]      hold_cnt;

`ifdef PIPE_EXC_EN
  logic [4:0]            exc_in;
  logic                  bd_in;
  logic [4:0]            exc_out;
  logic                  bd_out;

  modport master (
    output en, flush, valid_in, pc_in, instr_in, lanes_in, flags_in, fwd_sel,
           exc_in, bd_in,
    input  valid_out, pc_out, instr_out, lanes_out, flags_out, fwd_data,
           fwd_ok, hold_cnt, exc_out, bd_out
  );

  modport slave (
    input  en, flush, valid_in, pc_in, instr_in, lanes_in, flags_in, fwd_sel,
           exc_in, bd_in,
    output valid_out, pc_out, instr_out, lanes_out, flags_out, fwd_data,
           fwd_ok, hold_cnt, exc_out, bd_out
  );
`else
  modport master (
    output en, flush, valid_in, pc_in, instr_in, lanes_in, flags_in, fwd_sel,
    input  valid_out, pc_out, instr_out, lanes_out, flags_out, fwd_data,
           fwd_ok, hold_cnt
  );

  modport slave (
    input  en, flush, valid_in, pc_in, instr_in, lanes_in, flags_in, fwd_sel,
    output valid_out, pc_out, instr_out, lanes_out, flags_out, fwd_data,
           fwd_ok, hold_cnt
  );
`endif
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall, flush/bubble, hold-age counter and forwarding mux.
// Define PIPE_EXC_EN to carry exception code and branch-delay bit through the stage.
module pipe_stage_reg #(
  parameter int DW    = 32,
  parameter int NLANE = 2,
  parameter int FW    = 4,
  parameter int HOLDW = 4
) (
  input  logic              clk,
  input  logic              reset,
  pipe_stage_reg_if.slave   bus
);
  localparam logic [HOLDW-1:0] HOLD_MAX = {HOLDW{1'b1}};

  logic                  valid_reg;
  logic [DW-1:0]         pc_reg;
  logic [DW-1:0]         instr_reg;
  logic [NLANE*DW-1:0]   lanes_reg;
  logic [FW-1:0]         flags_reg;
  logic [HOLDW-1:0]      hold_reg;

  logic [DW-1:0]         lane_word [NLANE];
  logic [DW-1:0]         fwd_data_next;
  logic                  fwd_ok_next;
  logic                  exc_block;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
      lanes_reg <= '0;
      flags_reg <= '0;
      hold_reg  <= '0;
    end else if (bus.flush) begin
      // Bubble keeps the PC so a later exception can still report EPC.
      valid_reg <= 1'b0;
      pc_reg    <= bus.pc_in;
      instr_reg <= '0;
      lanes_reg <= '0;
      flags_reg <= '0;
      hold_reg  <= '0;
    end else if (bus.en) begin
      valid_reg <= bus.valid_in;
      pc_reg    <= bus.pc_in;
      instr_reg <= bus.instr_in;
      lanes_reg <= bus.lanes_in;
      flags_reg <= bus.flags_in;
      hold_reg  <= '0;
    end else if (valid_reg && (hold_reg != HOLD_MAX)) begin
      hold_reg  <= hold_reg + HOLDW'(1);
    end
  end

`ifdef PIPE_EXC_EN
  logic [4:0] exc_reg;
  logic       bd_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_reg <= '0;
      bd_reg  <= 1'b0;
    end else if (bus.flush) begin
      exc_reg <= '0;
      bd_reg  <= bus.bd_in;
    end else if (bus.en) begin
      exc_reg <= bus.exc_in;
      bd_reg  <= bus.bd_in;
    end
  end

  assign bus.exc_out = exc_reg;
  assign bus.bd_out  = bd_reg;
  assign exc_block   = (exc_reg != 5'd0);
`else
  assign exc_block   = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NLANE; gi++) begin : g_lane
      assign lane_word[gi] = lanes_reg[gi*DW +: DW];
    end
  endgenerate

  // Codes 1..NLANE pick a lane, 6 is the link address; 7 (DM read) and spare codes are never ready.
  always_comb begin
    fwd_data_next = '0;
    fwd_ok_next   = 1'b0;
    for (int k = 0; k < NLANE; k++) begin
      if (bus.fwd_sel == 3'(k + 1)) begin
        fwd_data_next = lane_word[k];
        fwd_ok_next   = valid_reg;
      end
    end
    if (bus.fwd_sel == 3'd6) begin
      fwd_data_next = pc_reg + DW'(8);
      fwd_ok_next   = valid_reg;
    end
    if (exc_block) begin
      fwd_ok_next = 1'b0;
    end
  end

  assign bus.valid_out = valid_reg;
  assign bus.pc_out    = pc_reg;
  assign bus.instr_out = instr_reg;
  assign bus.lanes_out = lanes_reg;
  assign bus.flags_out = flags_reg;
  assign bus.hold_cnt  = hold_reg;
  assign bus.fwd_data  = fwd_data_next;
  assign bus.fwd_ok    = fwd_ok_next;
endmodule
